// File: rtl/rv32i_types.sv
// Shared RV32I decode types; the load/store unit's FSM state and lane helpers live here too.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_t;

  // Undefined store widths behave as sw.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   store_mask = 4'b0001 << off;
      F3_SH:   store_mask = 4'b0011 << {off[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      F3_SB:   store_data = {4{rs2[7:0]}};
      F3_SH:   store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  function automatic logic misaligned_access(input logic is_store, input logic [2:0] f3,
                                             input logic [1:0] off);
    if (is_store) begin
      case (f3)
        F3_SB:   misaligned_access = 1'b0;
        F3_SH:   misaligned_access = off[0];
        default: misaligned_access = |off;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: misaligned_access = 1'b0;
        F3_LH, F3_LHU: misaligned_access = off[0];
        default:       misaligned_access = |off;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word and extends it.
module lsu_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata >> {off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one request/response memory access per instruction, stalls until done.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and flag misaligned.
module mem_stage_lsu
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  input  logic              advance,
  input  logic              flush,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wmask,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misaligned
);

  lsu_state_t        state_q, state_d;
  logic              dmem_read_q, dmem_read_d;
  logic              dmem_write_q, dmem_write_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_wmask_q, dmem_wmask_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              kill_q, kill_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              misaligned_q, misaligned_d;

  logic              accept;
  logic              trap;
  logic [31:0]       aligned_data;

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (aligned_data)
  );

  assign accept = (req_read | req_write) & ~flush;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned_access(req_write, req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    dmem_read_d  = dmem_read_q;
    dmem_write_d = dmem_write_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wmask_d = dmem_wmask_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    kill_d       = kill_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          off_d    = req_addr[1:0];
          funct3_d = req_funct3;
          kill_d   = 1'b0;
          if (trap) begin
            state_d      = LSU_DONE;
            misaligned_d = 1'b1;
            load_data_d  = 32'd0;
          end else begin
            // Write wins when both strobes arrive together.
            state_d      = LSU_ACCESS;
            dmem_write_d = req_write;
            dmem_read_d  = ~req_write;
            dmem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            dmem_wmask_d = req_write ? store_mask(req_funct3, req_addr[1:0]) : 4'b0000;
            dmem_wdata_d = store_data(req_funct3, req_wdata);
          end
        end
      end
      LSU_ACCESS: begin
        // The bus handshake cannot be aborted, so a flush only marks the result as dead.
        if (flush) kill_d = 1'b1;
        if (dmem_resp) begin
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          if (kill_q | flush) begin
            state_d = LSU_IDLE;
          end else begin
            state_d = LSU_DONE;
            if (dmem_read_q) load_data_d = aligned_data;
          end
        end
      end
      LSU_DONE: begin
        if (advance | flush) begin
          state_d      = LSU_IDLE;
          misaligned_d = 1'b0;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'd0;
      dmem_wmask_q <= 4'd0;
      off_q        <= 2'd0;
      funct3_q     <= 3'd0;
      kill_q       <= 1'b0;
      load_data_q  <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wmask_q <= dmem_wmask_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      kill_q       <= kill_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign stall      = ~rst & (((state_q == LSU_IDLE) & accept) | (state_q == LSU_ACCESS));
  assign dmem_read  = dmem_read_q;
  assign dmem_write = dmem_write_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wmask = dmem_wmask_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed + randomized bench for mem_stage_lsu against a byte-lane reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        advance, flush;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] load_data;
  logic        stall, misaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_load = 32'd0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .advance(advance), .flush(flush), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .load_data(load_data),
    .stall(stall), .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the ISA width rules; unknown encodings act as words.
  function automatic int ld_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int st_size(input logic [2:0] f3);
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                             input int start);
    int size = ld_size(f3);
    logic [31:0] v = rdata >> (8 * start);
    if (size == 4) return rdata;
    if (size == 1) v = (f3 == 3'd0 && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
    else           v = (f3 == 3'd1 && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
    return v;
  endfunction

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3, input int lat,
                        input logic [31:0] rdata, input int hold, input logic flush_mid,
                        input string tag);
    int size, start, nstall;
    logic trap;
    logic [3:0] emask;
    logic [31:0] ewdata, tmp;
    size  = wr ? st_size(f3) : ld_size(f3);
    start = (int'(addr[1:0]) / size) * size;
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = (int'(addr[1:0]) % size) != 0;
`endif
    emask = 4'b0000;
    ewdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      emask[i] = (i >= start) && (i < start + size);
      tmp = wd >> (8 * (i % size));
      ewdata[8*i +: 8] = tmp[7:0];
    end

    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    advance = 1'b0; flush = 1'b0; dmem_resp = 1'b0;
    #1 chk({tag, ".stall_idle"}, 32'(stall), 32'd1);
    @(negedge clk);
    if (trap) begin
      exp_load = 32'd0;
      chk({tag, ".trap_stall"}, 32'(stall), 32'd0);
      chk({tag, ".trap_strobe"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    end else begin
      chk({tag, ".write"}, 32'(dmem_write), 32'(wr));
      chk({tag, ".read"}, 32'(dmem_read), 32'(rd & ~wr));
      chk({tag, ".addr"}, dmem_addr, addr & 32'hFFFFFFFC);
      if (wr) begin
        chk({tag, ".wmask"}, 32'(dmem_wmask), 32'(emask));
        chk({tag, ".wdata"}, dmem_wdata, ewdata);
      end
      nstall = 1;
      for (int n = 0; n <= lat; n++) begin
        flush = flush_mid && (n == 0);
        if (n == lat) begin dmem_resp = 1'b1; dmem_rdata = rdata; end
        else dmem_rdata = $urandom;
        #1 if (stall) nstall++;
        chk({tag, ".strobe_held"}, 32'(dmem_read | dmem_write), 32'd1);
        @(negedge clk);
      end
      dmem_resp = 1'b0; flush = 1'b0; dmem_rdata = $urandom;
      chk({tag, ".stall_cycles"}, 32'(nstall), 32'(lat + 2));
      chk({tag, ".strobe_drop"}, {30'd0, dmem_read, dmem_write}, 32'd0);
      if (flush_mid) begin
        req_read = 1'b0; req_write = 1'b0;
        #1 chk({tag, ".kill_stall"}, 32'(stall), 32'd0);
        chk({tag, ".kill_load"}, load_data, exp_load);
        return;
      end
      if (rd && !wr) exp_load = model_load(rdata, f3, start);
      chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    end
    chk({tag, ".load_data"}, load_data, exp_load);
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(trap));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_strobe"}, {30'd0, dmem_read, dmem_write}, 32'd0);
      chk({tag, ".hold_load"}, load_data, exp_load);
      chk({tag, ".hold_stall"}, 32'(stall), 32'd0);
    end
    advance = 1'b1; req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    chk({tag, ".mis_clear"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = 32'd0;
    req_funct3 = 3'd2; advance = 1'b0; flush = 1'b0; dmem_rdata = 32'd0; dmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.wmask", 32'(dmem_wmask), 32'd0);
    chk("rst.load", load_data, 32'd0);
    chk("rst.mis", 32'(misaligned), 32'd0);
    req_read = 1'b0; rst = 1'b0;

    // Stray response while idle must not start anything.
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk); dmem_resp = 1'b0;
    chk("idle_resp.strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("idle_resp.load", load_data, 32'd0);

    run_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 3, 32'h0, 0, 1'b0, "sw");
    run_op(1'b1, 1'b0, 32'h103, 32'h0, 3'd0, 1, 32'h80FF1234, 0, 1'b0, "lb");
    run_op(1'b1, 1'b0, 32'h103, 32'h0, 3'd4, 0, 32'h80FF1234, 0, 1'b0, "lbu");
    run_op(1'b0, 1'b1, 32'h202, 32'h0000ABCD, 3'd1, 0, 32'h0, 0, 1'b0, "sh");
    run_op(1'b1, 1'b0, 32'h206, 32'h0, 3'd1, 2, 32'h80015555, 3, 1'b0, "lh");
    run_op(1'b1, 1'b1, 32'h301, 32'h000000A5, 3'd0, 1, 32'hFFFFFFFF, 1, 1'b0, "both");
    run_op(1'b1, 1'b0, 32'h400, 32'h0, 3'd2, 2, 32'hCAFEF00D, 0, 1'b1, "flush");
    run_op(1'b1, 1'b0, 32'h101, 32'h0, 3'd2, 1, 32'h11223344, 0, 1'b0, "lw_mis");

    // Reset in the middle of an access; a late response is ignored.
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_funct3 = 3'd2;
    @(negedge clk);
    chk("rstacc.read", 32'(dmem_read), 32'd1);
    rst = 1'b1;
    #1 chk("rstacc.stall_in_rst", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_read = 1'b0; exp_load = 32'd0;
    #1 chk("rstacc.strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rstacc.stall", 32'(stall), 32'd0);
    chk("rstacc.load", load_data, 32'd0);
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(negedge clk); dmem_resp = 1'b0;
    chk("rstacc.late_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rstacc.late_load", load_data, 32'd0);

    for (int k = 0; k < 40; k++) begin
      logic wr_r;
      wr_r = 1'($urandom_range(0, 1));
      run_op(~wr_r | 1'($urandom_range(0, 1)), wr_r, $urandom, $urandom,
             3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom,
             $urandom_range(0, 2), 1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
